// File: rtl/serial_subtractor_32bit.sv
// serial_subtractor_32bit
//   Multi-cycle 32-bit subtractor: D = A - B - Bin, computed one 4-bit slice
//   per clock (least significant slice first) with a registered borrow
//   rippling between slices. Eight slice steps per operation.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request; accepted in IDLE or DONE, ignored in RUN
//   A, B   : minuend / subtrahend, latched when start is accepted
//   Bin    : borrow-in, latched when start is accepted
//   D      : difference (modulo 2^32)
//   Bout   : unsigned borrow-out (A < B + Bin)
//   V      : two's-complement overflow of A - B - Bin
//   busy   : high while slices are being computed
//   done   : one-cycle pulse when D/Bout/V are valid
module serial_subtractor_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Bin,
    output logic [31:0] D,
    output logic        Bout,
    output logic        V,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        bor;
    logic [2:0]  i;

    // Current slice operands and 5-bit slice result {borrow, diff}.
    // Bit 4 of the 5-bit difference is set exactly when the slice underflows.
    logic [4:0]  sl_base;
    logic [3:0]  a_s;
    logic [3:0]  b_s;
    logic [4:0]  diff;

    assign sl_base = {i, 2'b00};
    assign a_s     = a_r[sl_base +: 4];
    assign b_s     = b_r[sl_base +: 4];
    assign diff    = {1'b0, a_s} - {1'b0, b_s} - {4'b0000, bor};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            bor   <= 1'b0;
            i     <= '0;
            D     <= '0;
            Bout  <= 1'b0;
            V     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        bor   <= Bin;
                        i     <= '0;
                        D     <= '0;
                        Bout  <= 1'b0;
                        V     <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    D[sl_base +: 4] <= diff[3:0];
                    bor             <= diff[4];
                    i               <= i + 3'd1;
                    if (i == 3'd7) begin
                        // Top slice: diff[3] is the new D[31], so flags can be
                        // resolved in the same edge that finishes D.
                        Bout  <= diff[4];
                        V     <= (a_r[31] ^ b_r[31]) & (diff[3] ^ a_r[31]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// Directed + random bench for serial_subtractor_32bit.
module tb_serial_subtractor_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic [31:0] D;
    logic        Bout;
    logic        V;
    logic        busy;
    logic        done;

    int n_run  = 0;
    int n_fail = 0;

    serial_subtractor_32bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .D     (D),
        .Bout  (Bout),
        .V     (V),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present operands with start, step to the accepting edge, drop start.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done; optionally fire a spurious start mid-RUN.
    task automatic wait_done(input bit inject, output int cnt);
        bit bz;
        cnt = 0;
        bz  = 0;
        while (!done && cnt < 20) begin
            if (inject && cnt == 3) begin
                start = 1'b1; A = 32'hFFFF_0000; B = 32'h0000_1111; Bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!busy) bz = 1;
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        if (bz) chk("busy_during_run", 32'(bz), 32'd0);
        if (done) chk("busy_with_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic bin, input logic [31:0] ed, input logic eb, input logic ev);
        int cnt;
        start_op(a, b, bin);
        wait_done(1'b0, cnt);
        chk({tag, "_lat"}, cnt, 8);
        chk({tag, "_D"}, D, ed);
        chk({tag, "_Bout"}, {31'd0, Bout}, {31'd0, eb});
        chk({tag, "_V"}, {31'd0, V}, {31'd0, ev});
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int          cnt;
        bit          seen;
        logic [31:0] ra, rb;
        logic        rbin;
        logic [32:0] full;
        logic        ev;
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        logic [31:0] pd [3];

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_D", D, 32'd0);
        chk("rst_flags", {27'd0, Bout, V, busy, done, 1'b0}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        run_dir("5m3",      32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0);
        run_dir("0m0b1",    32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_dir("min_m1",   32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_dir("max_mneg", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b1);
        run_dir("eq_b1",    32'h1234_5678,  32'h1234_5678,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Spurious start mid-RUN must be ignored.
        start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
        wait_done(1'b1, cnt);
        chk("ign_lat", cnt, 8);
        chk("ign_D", D, 32'h0246_8ACF);
        chk("ign_Bout", {31'd0, Bout}, 32'd0);
        @(posedge clk); #1;
        chk("ign_no_restart", {31'd0, busy}, 32'd0);

        // Asynchronous reset at RUN cycle 4: no done, outputs cleared at once.
        start_op(32'd100, 32'd1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_partial", D, 32'h0000_0063);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_D", D, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        chk("rst_no_done", 32'(seen), 32'd0);
        run_dir("after_rst", 32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0);

        // start held high, new operands presented during each DONE cycle.
        pa[0] = 32'd10;          pb[0] = 32'd3;  pd[0] = 32'd7;
        pa[1] = 32'hFFFF_FFFF;   pb[1] = 32'd2;  pd[1] = 32'hFFFF_FFFD;
        pa[2] = 32'd1;           pb[2] = 32'd2;  pd[2] = 32'hFFFF_FFFF;
        @(negedge clk);
        A = pa[0]; B = pb[0]; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 3; n++) begin
            cnt = 0;
            do begin
                @(posedge clk); #1;
                cnt++;
            end while (!done && cnt < 20);
            chk($sformatf("b2b%0d_spacing", n), cnt, (n == 0) ? 8 : 9);
            chk($sformatf("b2b%0d_D", n), D, pd[n]);
            if (n < 2) begin
                A = pa[n+1]; B = pb[n+1];
            end else begin
                start = 1'b0;
            end
        end
        chk("b2b2_Bout", {31'd0, Bout}, 32'd1);
        repeat (2) @(posedge clk);

        // Random sweep against a 33-bit reference subtraction.
        for (int k = 0; k < 1000; k++) begin
            ra   = $urandom;
            rb   = (k % 7 == 0) ? ra : $urandom;
            rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {32'd0, rbin};
            ev   = (ra[31] ^ rb[31]) & (full[31] ^ ra[31]);
            start_op(ra, rb, rbin);
            wait_done(1'b0, cnt);
            chk("rnd_lat", cnt, 8);
            chk("rnd_D", D, full[31:0]);
            chk("rnd_flags", {30'd0, Bout, V}, {30'd0, full[32], ev});
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
